// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constant tables for the byte-substitution engine.
//   state_t  - engine control state (IDLE / BUSY / DONE)
//   SBOX_FWD - FIPS-197 forward S-box, indexed by input byte
//   SBOX_INV - FIPS-197 inverse S-box, indexed by input byte
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_dual.sv
// sbox_dual: combinational single-byte S-box lookup, forward or inverse.
//   i_byte - byte to substitute
//   i_inv  - 0 selects forward table, 1 selects inverse table
//   o_byte - substituted byte
module sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_inv,
  output logic [7:0] o_byte
);

  assign o_byte = i_inv ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];

endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: iterative AES SubBytes / InvSubBytes over an NBYTES word,
// NSBOX bytes per cycle, with valid/ready handshakes on both sides.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake (ready only in IDLE)
//   in_data, in_inv     - word and direction, captured on accept
//   out_valid/out_ready - output handshake (valid only in DONE)
//   out_data            - work register (substituted word when out_valid)
//   busy                - engine not in IDLE
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned NSBOX  = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  localparam int unsigned DW     = 8 * NBYTES;
  localparam int unsigned NCHUNK = NBYTES / NSBOX;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned BW     = (DW > 1) ? $clog2(DW) : 1;

  // Elaboration guard: the word must split into whole chunks.
  if ((NSBOX == 0) || ((NBYTES % NSBOX) != 0)) begin : g_bad_params
    $error("sub_bytes_engine: NBYTES must be a non-zero multiple of NSBOX");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_mode;
  logic [DW-1:0]   r_work;
  logic            w_accept;
  logic            w_last;
  logic [31:0]     w_base;
  logic [BW-1:0]   w_off      [NSBOX];
  logic [7:0]      w_lane_in  [NSBOX];
  logic [7:0]      w_lane_out [NSBOX];

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_last   = (r_cnt == CW'(NCHUNK - 1));
  assign w_base   = 32'(r_cnt) * NSBOX;

  // Bit offset and current value of each lane's byte within the work register.
  always_comb begin
    for (int unsigned k = 0; k < NSBOX; k++) begin
      w_off[k]     = BW'((w_base + 32'(k)) * 32'd8);
      w_lane_in[k] = r_work[w_off[k] +: 8];
    end
  end

  for (genvar k = 0; k < int'(NSBOX); k++) begin : g_lane
    sbox_dual u_sbox (
      .i_byte (w_lane_in[k]),
      .i_inv  (r_mode),
      .o_byte (w_lane_out[k])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, substitute one chunk per BUSY cycle.
  // The counter stops at the last chunk so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_work <= in_data;
      r_mode <= in_inv;
      r_cnt  <= '0;
    end else if (r_state == ST_BUSY) begin
      for (int unsigned k = 0; k < NSBOX; k++) begin
        r_work[w_off[k] +: 8] <= w_lane_out[k];
      end
      if (!w_last) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign out_data = r_work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: self-checking bench for sub_bytes_engine.
// Three instances (NSBOX = 1, 4, 16) share clk/rst; expected values come from
// an S-box model derived from GF(2^8) inversion plus the affine transform.
module tb_sub_bytes_engine;

  localparam int NB = 16;
  localparam int NI = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid  [NI];
  logic              in_inv    [NI];
  logic              out_ready [NI];
  logic [8*NB-1:0]   in_data   [NI];
  logic              in_ready  [NI];
  logic              out_valid [NI];
  logic              busy      [NI];
  logic [8*NB-1:0]   out_data  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  always #5 clk = ~clk;

  sub_bytes_engine #(.NBYTES(NB), .NSBOX(1)) u_ns1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  sub_bytes_engine #(.NBYTES(NB), .NSBOX(4)) u_ns4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  sub_bytes_engine #(.NBYTES(NB), .NSBOX(16)) u_ns16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  function automatic int exp_lat(input int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 1;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_model();
    logic [7:0] x, y, iv, s;
    for (int i = 0; i < 256; i++) begin
      x  = 8'(i);
      iv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (x != 8'h00 && gmul(x, y) == 8'h01) iv = y;
      end
      s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
      m_fwd[i] = s;
      m_inv[s] = x;
    end
  endtask

  function automatic logic [8*NB-1:0] model_word(input logic [8*NB-1:0] w, input logic inv);
    logic [8*NB-1:0] r;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = inv ? m_inv[w[8*i +: 8]] : m_fwd[w[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [8*NB-1:0] act, input logic [8*NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, measure accept-to-valid cycles, collect and release it.
  task automatic run_word(input int d, input logic [8*NB-1:0] w, input logic inv,
                          output logic [8*NB-1:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready[d] && guard < 50) begin tick(); guard++; end
    if (guard >= 50) check("ready_timeout", 0, 1);
    in_valid[d] = 1'b1; in_data[d] = w; in_inv[d] = inv;
    tick();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 100) begin tick(); lat++; end
    if (!out_valid[d]) check("valid_timeout", 0, 1);
    res = out_data[d];
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  typedef struct {
    string           name;
    logic [8*NB-1:0] din;
    logic            inv;
    logic [8*NB-1:0] exp;
  } vec_t;

  initial begin
    vec_t            vt [7];
    logic [8*NB-1:0] res, res2, w, saved;
    int              lat;
    bit              saw_valid;

    rst = 1'b0;
    for (int d = 0; d < NI; d++) begin
      in_valid[d] = 1'b0; in_inv[d] = 1'b0; out_ready[d] = 1'b0; in_data[d] = '0;
    end
    build_model();
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < NI; d++) begin
      check("rst_in_ready",  128'(in_ready[d]),  128'd1);
      check("rst_out_valid", 128'(out_valid[d]), 128'd0);
      check("rst_busy",      128'(busy[d]),      128'd0);
      check("rst_out_data",  out_data[d],        '0);
    end
    tick();
    rst = 1'b0;

    vt[0] = '{"fwd_00",  {16{8'h00}}, 1'b0, {16{8'h63}}};
    vt[1] = '{"inv_63",  {16{8'h63}}, 1'b1, {16{8'h00}}};
    vt[2] = '{"fwd_53",  {16{8'h53}}, 1'b0, {16{8'hed}}};
    vt[3] = '{"fwd_ff",  {16{8'hff}}, 1'b0, {16{8'h16}}};
    vt[4] = '{"inv_ed",  {16{8'hed}}, 1'b1, {16{8'h53}}};
    vt[5] = '{"inv_16",  {16{8'h16}}, 1'b1, {16{8'hff}}};
    vt[6] = '{"fwd_ramp", 128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
              128'h76abd7fe2b670130c56f6bf27b777c63};

    for (int v = 0; v < 7; v++) begin
      run_word(1, vt[v].din, vt[v].inv, res, lat);
      check(vt[v].name, res, vt[v].exp);
      check("vec_latency", 128'(lat), 128'(exp_lat(1)));
    end

    // Random round trip on all three lane widths.
    for (int d = 0; d < NI; d++) begin
      for (int n = 0; n < 200; n++) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        run_word(d, w, 1'b0, res, lat);
        check("rt_fwd", res, model_word(w, 1'b0));
        check("rt_fwd_lat", 128'(lat), 128'(exp_lat(d)));
        run_word(d, res, 1'b1, res2, lat);
        check("rt_inv", res2, w);
        check("rt_inv_lat", 128'(lat), 128'(exp_lat(d)));
      end
    end

    // Backpressure: result held for 10 cycles, then one-cycle release.
    w = 128'h00112233445566778899aabbccddeeff;
    in_valid[1] = 1'b1; in_data[1] = w; in_inv[1] = 1'b0;
    tick();
    in_valid[1] = 1'b0;
    lat = 0;
    while (!out_valid[1] && lat < 100) begin tick(); lat++; end
    check("bp_valid", 128'(out_valid[1]), 128'd1);
    saved = out_data[1];
    check("bp_data", saved, model_word(w, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 128'(out_valid[1]), 128'd1);
      check("bp_hold_data",  out_data[1],        saved);
      check("bp_hold_ready", 128'(in_ready[1]),  128'd0);
    end
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    check("bp_rel_ready", 128'(in_ready[1]),  128'd1);
    check("bp_rel_valid", 128'(out_valid[1]), 128'd0);
    check("bp_rel_busy",  128'(busy[1]),      128'd0);

    // Reset in the second BUSY cycle drops the word.
    in_valid[1] = 1'b1; in_data[1] = {16{8'hab}}; in_inv[1] = 1'b0;
    tick();
    in_valid[1] = 1'b0;
    tick();
    check("mid_busy_before_rst", 128'(busy[1]), 128'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready",  128'(in_ready[1]),  128'd1);
    check("mid_rst_out_valid", 128'(out_valid[1]), 128'd0);
    check("mid_rst_busy",      128'(busy[1]),      128'd0);
    check("mid_rst_out_data",  out_data[1],        '0);
    #2 rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid[1]) saw_valid = 1'b1;
    end
    check("mid_rst_no_valid", 128'(saw_valid), 128'd0);
    w = {$urandom, $urandom, $urandom, $urandom};
    run_word(1, w, 1'b1, res, lat);
    check("post_rst_word", res, model_word(w, 1'b1));
    check("post_rst_lat",  128'(lat), 128'(exp_lat(1)));

    // Inputs toggled during BUSY must not disturb the captured word.
    w = {$urandom, $urandom, $urandom, $urandom};
    in_valid[1] = 1'b1; in_data[1] = w; in_inv[1] = 1'b0;
    tick();
    lat = 0;
    while (!out_valid[1] && lat < 100) begin
      in_data[1] = {$urandom, $urandom, $urandom, $urandom};
      in_inv[1]  = ~in_inv[1];
      tick();
      lat++;
    end
    in_valid[1] = 1'b0;
    check("toggle_lat",  128'(lat), 128'(exp_lat(1)));
    check("toggle_data", out_data[1], model_word(w, 1'b0));
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    check("toggle_idle", 128'(in_ready[1]), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 SHALL have parameter NBYTES, default 16: bytes per data word.
REQ-002 SHALL have parameter NSBOX, default 4: byte-substitution lanes per cycle; NBYTES % NSBOX == 0, NSBOX >= 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input word offered.
REQ-006 SHALL have port in_ready  output  1  engine can accept a word.
REQ-007 SHALL have port in_data  input  8*NBYTES  input word; byte i = bits [8i+7:8i].
REQ-008 SHALL have port in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the word.
REQ-009 SHALL have port out_valid  output  1  result word available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_data  output  8*NBYTES  substituted word, same byte order as in_data.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; it SHALL be decoded from state only, with no combinational path from in_valid.
REQ-015 SHALL accept on the rising edge where in_valid && in_ready: capture in_data into the work register, capture in_inv into the mode register, clear chunk counter to 0, and go to BUSY.
REQ-016 SHALL, on each BUSY edge, replace bytes cnt*NSBOX .. cnt*NSBOX+NSBOX-1 of the work register with their forward or inverse FIPS-197 substitutes, then increment cnt.
REQ-017 SHALL go BUSY -> DONE on the edge that processes chunk C-1, where C = NBYTES/NSBOX; the counter SHALL be ceil(log2(C)) bits, minimum 1 bit, and SHALL never wrap during BUSY.
REQ-018 SHALL assert out_valid exactly C cycles after the accept edge. With defaults this is 4 cycles; with NSBOX = NBYTES it is 1 cycle.
REQ-019 SHALL drive out_valid = 1 only in DONE and out_data = the work register; out_data SHALL be held stable while out_valid && !out_ready.
REQ-020 SHALL go DONE -> IDLE on an edge with out_ready = 1; a new word is not accepted in that same cycle, because in_ready = 0 in DONE.
REQ-021 SHALL ignore in_valid, in_data and in_inv outside IDLE; a mode change mid-word SHALL NOT affect the word in flight.
REQ-022 SHALL NOT include a throughput bypass: minimum accept-to-accept spacing is C+2 cycles when out_ready is held at 1.
REQ-023 SHALL make out_data in IDLE and BUSY equal to the work register contents; it is don't-care to the consumer, and the bench checks it only under out_valid.

Reset
REQ-024 SHALL, on rst = 1, immediately and asynchronously force state = IDLE, cnt = 0, mode = 0 and work register = 0.
REQ-025 SHALL therefore drive the outputs during and after reset as in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
REQ-026 SHALL, if reset is asserted during BUSY or DONE, drop the word in flight, produce no out_valid for it, and be ready to accept on the first edge after rst deasserts.

Structure
REQ-027 SHALL place the state enum (IDLE/BUSY/DONE) and the 256-entry forward and inverse S-box byte tables in the shared package aes_pkg.
REQ-028 SHALL use one sub-module, sbox_dual: combinational byte lookup with an inv select. It SHALL be instantiated NSBOX times, with lane k indexed by cnt*NSBOX+k.
REQ-029 SHALL reject at elaboration any parameter set with NBYTES % NSBOX != 0.

Verification
REQ-030 SHALL cover forward mode, defaults: in_data = all bytes 00, in_inv = 0 -> after 4 cycles out_data = all bytes 63. Spot checks: byte 53 -> ED, byte FF -> 16.
REQ-031 SHALL cover inverse mode: in_data = all bytes 63, in_inv = 1 -> all bytes 00. Spot checks: ED -> 53, 16 -> FF.
REQ-032 SHALL cover round trip: 200 random words forward then inverse -> equal to the original. Run with NSBOX = 1, 4 and 16, and check latency = 16, 4 and 1 cycles respectively.
REQ-033 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready stays 0. Raising out_ready for one cycle -> IDLE and in_ready = 1 on the next cycle.
REQ-034 SHALL cover reset mid-word: rst pulse at BUSY cycle 2 -> outputs immediately at reset values, no out_valid for that word, next word accepted and correct.
REQ-035 SHALL cover mode and data toggled during BUSY: in_inv and in_data changed every cycle during BUSY -> the result matches the values captured at accept.
